// File: rtl/ram_bist_initiator.sv
// ram_bist_initiator
// Built-in self-test sequencer for a single-port RAM. On an accepted start it
// writes seed+k to base_addr+k for every word in the window, reads the window
// back, checks each returned word against the regenerated pattern, and
// reports pass/fail, a saturating error count and the first failing address.
// While a test is running this block is the only master on the RAM port.

module ram_bist_initiator #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] num_words,
  input  logic [DW-1:0] seed,

  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] first_err_addr,

  output logic          read,
  output logic          write,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data,
  input  logic [DW-1:0] read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Test parameters captured when a start is accepted
  logic [AW-1:0] base_q;
  logic [AW-1:0] count_q;
  logic [DW-1:0] seed_q;

  // Word index within the window for the current write or read sweep
  logic [AW-1:0] idx_q;

  // Read-compare pipeline: stage 0 is the newest entry, stage RD_LAT-1 the
  // entry whose read data is on read_data this cycle
  logic [RD_LAT-1:0] pipe_vld;
  logic [DW-1:0]     pipe_exp  [RD_LAT];
  logic [AW-1:0]     pipe_addr [RD_LAT];

  logic          start_ok;
  logic          last_idx;
  logic          young_pending;
  logic          mature;
  logic          mismatch;
  logic [DW-1:0] exp_word;
  logic [15:0]   err_next;

  assign start_ok = (state == S_IDLE) && start;
  assign last_idx = (idx_q == count_q - AW'(1));
  assign exp_word = seed_q + DW'(idx_q);

  // Anything still in flight other than the oldest stage means another
  // comparison is due after this cycle, so draining is not finished yet
  assign young_pending = |(pipe_vld << 1);

  assign mature   = pipe_vld[RD_LAT-1];
  assign mismatch = mature && (read_data != pipe_exp[RD_LAT-1]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: write sweep, read sweep, wait for last compare, report
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (last_idx) begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        if (last_idx) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!young_pending) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Strobes and status decoded straight from the state so they can never overlap
  always_comb begin
    write = 1'b0;
    read  = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_WRITE: begin
        write = 1'b1;
        busy  = 1'b1;
      end
      S_READ: begin
        read = 1'b1;
        busy = 1'b1;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Address/data generation: both wrap naturally at their register widths
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      count_q <= '0;
      seed_q  <= '0;
      idx_q   <= '0;
      address <= '0;
      data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            count_q <= num_words;
            seed_q  <= seed;
            idx_q   <= '0;
            address <= base_addr;
            data    <= seed;
          end
        end
        S_WRITE: begin
          if (last_idx) begin
            idx_q   <= '0;
            address <= base_q;
          end else begin
            idx_q   <= idx_q + AW'(1);
            address <= address + AW'(1);
            data    <= data + DW'(1);
          end
        end
        S_READ: begin
          if (!last_idx) begin
            idx_q   <= idx_q + AW'(1);
            address <= address + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Expected-value pipeline matching the RAM read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_exp[k]  <= '0;
        pipe_addr[k] <= '0;
      end
    end else begin
      pipe_vld[0]  <= (state == S_READ);
      pipe_exp[0]  <= exp_word;
      pipe_addr[0] <= address;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_exp[k]  <= pipe_exp[k-1];
        pipe_addr[k] <= pipe_addr[k-1];
      end
    end
  end

  // Error count including this cycle's comparison, saturating at all-ones
  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != 16'hFFFF)) begin
      err_next = err_count + 16'd1;
    end
  end

  // Result registers: cleared on start, updated by compares, pass decided on DONE entry
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else if (start_ok) begin
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= (num_words == '0);
    end else begin
      err_count <= err_next;
      if (mismatch && (err_count == 16'd0)) begin
        first_err_addr <= pipe_addr[RD_LAT-1];
      end
      if (state_next == S_DONE) begin
        pass <= (err_next == 16'd0);
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_initiator.sv
// Directed testbench for ram_bist_initiator: one instance with RD_LAT=1 checked
// cycle by cycle, one with RD_LAT=3 checked for done timing and results.

module tb_ram_bist_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start3;
  logic [31:0] base_addr;
  logic [31:0] num_words;
  logic [31:0] seed;

  logic        busy, done, pass, read, write;
  logic [15:0] err_count;
  logic [31:0] first_err_addr, address, data, read_data;

  logic        busy3, done3, pass3, read3, write3;
  logic [15:0] err_count3;
  logic [31:0] first_err_addr3, address3, data3, read_data3;

  logic [3:0]  bad_words;
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] rd1;
  logic [31:0] p3 [0:2];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ram_bist_initiator #(.AW(32), .DW(32), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .read(read),
    .write(write), .address(address), .data(data), .read_data(read_data)
  );

  ram_bist_initiator #(.AW(32), .DW(32), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .base_addr(base_addr),
    .num_words(num_words), .seed(seed), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .first_err_addr(first_err_addr3), .read(read3),
    .write(write3), .address(address3), .data(data3), .read_data(read_data3)
  );

  // Words 0..3 can be forced to read back 32'hDEAD to inject faults
  function automatic logic [31:0] ram_word(input logic [31:0] a, input logic [31:0] v);
    if (a < 32'd4 && bad_words[a[1:0]]) return 32'hDEAD;
    return v;
  endfunction

  // Behavioural RAM, one cycle read latency
  always @(posedge clk) begin
    if (write) mem1[address[5:0]] <= data;
    rd1 <= ram_word(address, mem1[address[5:0]]);
  end
  assign read_data = rd1;

  // Behavioural RAM, three cycle read latency
  always @(posedge clk) begin
    if (write3) mem3[address3[5:0]] <= data3;
    p3[0] <= ram_word(address3, mem3[address3[5:0]]);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign read_data3 = p3[2];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge: raises start for the remainder of the current cycle
  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] n,
                               input logic [31:0] s, input logic lat3);
    base_addr = b;
    num_words = n;
    seed      = s;
    if (lat3) start3 = 1'b1;
    else      start  = 1'b1;
  endtask

  // Full cycle-by-cycle check of one RD_LAT=1 test; extra_j re-asserts start in that cycle
  task automatic run1(input string name, input logic [31:0] b, input int n,
                      input logic [31:0] s, input logic [15:0] e_err,
                      input logic [31:0] e_first, input logic e_pass, input int extra_j);
    int last_j;
    int done_j;
    logic ew, er, eb, ed;
    applyStimulus(b, n, s, 1'b0);
    done_j = (n == 0) ? 1 : 2 * n + 2;
    last_j = (n == 0) ? 3 : 2 * n + 3;
    for (int j = 1; j <= last_j; j++) begin
      @(negedge clk);
      start = (j == extra_j);
      ew = (n != 0) && (j <= n);
      er = (n != 0) && (j > n) && (j <= 2 * n);
      eb = (n != 0) && (j <= 2 * n + 1);
      ed = (j == done_j);
      checkOutput({name, " wr/rd/busy/done"}, {60'd0, write, read, busy, done},
                  {60'd0, ew, er, eb, ed});
      if (ew) begin
        checkOutput({name, " wr addr"}, {32'd0, address}, {32'd0, b + 32'(j - 1)});
        checkOutput({name, " wr data"}, {32'd0, data}, {32'd0, s + 32'(j - 1)});
      end
      if (er) begin
        checkOutput({name, " rd addr"}, {32'd0, address}, {32'd0, b + 32'(j - 1 - n)});
      end
      if (j >= done_j) begin
        checkOutput({name, " pass"}, {63'd0, pass}, {63'd0, e_pass});
        checkOutput({name, " err_count"}, {48'd0, err_count}, {48'd0, e_err});
        checkOutput({name, " first_err_addr"}, {32'd0, first_err_addr}, {32'd0, e_first});
      end
    end
  endtask

  // RD_LAT=3 test: done must land at T+2N+4 exactly once with correct results
  task automatic run3(input string name, input logic [31:0] b, input int n,
                      input logic [31:0] s, input logic [15:0] e_err,
                      input logic [31:0] e_first, input logic e_pass);
    int done_j = -1;
    int done_cnt = 0;
    logic        got_pass = 1'b0;
    logic [15:0] got_err = 16'd0;
    logic [31:0] got_first = 32'd0;
    applyStimulus(b, n, s, 1'b1);
    for (int j = 1; j <= 2 * n + 8; j++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (done3) begin
        done_cnt++;
        done_j    = j;
        got_pass  = pass3;
        got_err   = err_count3;
        got_first = first_err_addr3;
      end
    end
    checkOutput({name, " done cycle"}, 64'(done_j), 64'(2 * n + 4));
    checkOutput({name, " done count"}, 64'(done_cnt), 64'd1);
    checkOutput({name, " pass"}, {63'd0, got_pass}, {63'd0, e_pass});
    checkOutput({name, " err_count"}, {48'd0, got_err}, {48'd0, e_err});
    checkOutput({name, " first_err_addr"}, {32'd0, got_first}, {32'd0, e_first});
  endtask

  initial begin
    int done_cnt;
    reset     = 1'b1;
    start     = 1'b0;
    start3    = 1'b0;
    base_addr = '0;
    num_words = '0;
    seed      = '0;
    bad_words = 4'b0000;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst busy/done/pass", {61'd0, busy, done, pass}, 64'd0);
    checkOutput("rst read/write", {62'd0, read, write}, 64'd0);
    checkOutput("rst err_count", {48'd0, err_count}, 64'd0);
    checkOutput("rst first_err_addr", {32'd0, first_err_addr}, 64'd0);
    checkOutput("rst address", {32'd0, address}, 64'd0);
    checkOutput("rst data", {32'd0, data}, 64'd0);
    checkOutput("rst lat3 busy/done/pass", {61'd0, busy3, done3, pass3}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle strobes", {62'd0, read, write}, 64'd0);
    end

    $display("[TB] clean pass");
    run1("clean", 32'h0, 4, 32'h10, 16'd0, 32'd0, 1'b1, 0);

    $display("[TB] fault on word 2");
    bad_words = 4'b0100;
    run1("fault2", 32'h0, 4, 32'h10, 16'd1, 32'd2, 1'b0, 0);

    $display("[TB] faults on words 1 and 3");
    bad_words = 4'b1010;
    run1("fault13", 32'h0, 4, 32'h10, 16'd2, 32'd1, 1'b0, 0);
    bad_words = 4'b0000;

    $display("[TB] zero-length window");
    run1("zero", 32'h20, 0, 32'h55, 16'd0, 32'd0, 1'b1, 0);

    $display("[TB] address and data wrap");
    run1("wrap", 32'hFFFF_FFFE, 4, 32'hFFFF_FFFF, 16'd0, 32'd0, 1'b1, 0);

    $display("[TB] start while busy is ignored");
    run1("midstart", 32'h8, 4, 32'h300, 16'd0, 32'd0, 1'b1, 2);

    $display("[TB] back-to-back start after done");
    bad_words = 4'b0100;
    run1("b2b_a", 32'h0, 3, 32'h77, 16'd1, 32'd2, 1'b0, 0);
    bad_words = 4'b0000;
    run1("b2b_b", 32'h10, 5, 32'h1000, 16'd0, 32'd0, 1'b1, 0);

    $display("[TB] reset during read");
    bad_words = 4'b0001;
    applyStimulus(32'h0, 32'd8, 32'h40, 1'b0);
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("midrst reading", {63'd0, read}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst strobes dropped", {61'd0, read, write, busy}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("midrst done pulses", 64'(done_cnt), 64'd0);
    checkOutput("midrst err_count", {48'd0, err_count}, 64'd0);
    checkOutput("midrst pass", {63'd0, pass}, 64'd0);
    bad_words = 4'b0000;

    $display("[TB] read latency 3");
    run3("lat3 clean", 32'h0, 4, 32'h10, 16'd0, 32'd0, 1'b1);
    bad_words = 4'b1010;
    run3("lat3 fault13", 32'h0, 4, 32'h10, 16'd2, 32'd1, 1'b0);
    bad_words = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
